// File: rtl/bbh_crc8_inserter.sv
// BBHEADER CRC-8 inserter.
// Computes CRC-8 (poly 0xD5, init 0x00, MSB-first, no reflection, no final XOR)
// over the first HDR_LEN bytes of each frame. The result is inserted as the
// next byte, and the data field is then passed through up to end of frame.
// Optional build macro BBH_MODE_XOR_EN adds a mode_hem input. Its value is
// captured on the sop byte and XORed into bit 0 of the inserted CRC byte.
module bbh_crc8_inserter #(
  parameter int unsigned HDR_LEN = 9
) (
`ifdef BBH_MODE_XOR_EN
  input  logic       mode_hem,
`endif
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic       in_eop,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  input  logic       out_ready,
  output logic [7:0] crc_out,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StHdr, StCrc, StData} state_e;

  // Index of the last header byte, as seen by the received-byte counter.
  localparam logic [3:0] LastIdx = 4'(HDR_LEN - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] crc_q;
  logic       eop_pend_q;  // last header byte also ended the frame
  logic       out_free;
  logic       accept;
  logic [7:0] crc_ins;

  // One byte of MSB-first CRC-8 update, polynomial 0xD5.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'hD5) : (c << 1);
    end
    return c;
  endfunction

`ifdef BBH_MODE_XOR_EN
  logic hem_q;
  assign crc_ins = crc_q ^ {7'b0, hem_q};
`else
  assign crc_ins = crc_q;
`endif

  assign out_free = !out_valid || out_ready;
  assign in_ready = !RST && out_free && (state_q != StCrc);
  assign accept   = in_valid && in_ready;

  // Frame FSM, CRC register and registered output stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      crc_q      <= 8'h00;
      eop_pend_q <= 1'b0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      crc_out    <= 8'h00;
      err        <= 1'b0;
`ifdef BBH_MODE_XOR_EN
      hem_q      <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (state_q == StCrc) begin
        // Insert the CRC byte as soon as the output register frees up.
        if (out_free) begin
          out_valid <= 1'b1;
          out_data  <= crc_ins;
          out_sop   <= 1'b0;
          out_eop   <= eop_pend_q;
          crc_out   <= crc_ins;
          state_q   <= eop_pend_q ? StIdle : StData;
        end
      end else if (accept) begin
        if (in_sop) begin
          // A sop always opens a new frame; outside IDLE it abandons the old one.
          out_valid <= 1'b1;
          out_data  <= in_data;
          out_sop   <= 1'b1;
          out_eop   <= 1'b0;
          crc_q     <= crc8_byte(8'h00, in_data);
          cnt_q     <= 4'd1;
`ifdef BBH_MODE_XOR_EN
          hem_q     <= mode_hem;
`endif
          if (state_q != StIdle) begin
            err <= 1'b1;
          end
          if (LastIdx == 4'd0) begin
            eop_pend_q <= in_eop;
            state_q    <= StCrc;
          end else if (in_eop) begin
            out_eop <= 1'b1;
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            state_q <= StHdr;
          end
        end else begin
          unique case (state_q)
            StIdle: begin
              // Out-of-frame bytes are dropped silently.
            end
            StHdr: begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              crc_q     <= crc8_byte(crc_q, in_data);
              cnt_q     <= cnt_q + 4'd1;
              if (cnt_q == LastIdx) begin
                eop_pend_q <= in_eop;
                state_q    <= StCrc;
              end else if (in_eop) begin
                // Truncated header: close the frame without a CRC byte.
                out_eop <= 1'b1;
                err     <= 1'b1;
                state_q <= StIdle;
              end
            end
            StData: begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_sop   <= 1'b0;
              out_eop   <= in_eop;
              if (in_eop) begin
                state_q <= StIdle;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bbh_crc8_inserter.sv
// Scoreboard bench for bbh_crc8_inserter.
// Expected output bytes are queued when the input byte is accepted and
// popped when the DUT transfers an output byte.
module tb_bbh_crc8_inserter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic       out_ready = 1'b1;
  logic [7:0] crc_out;
  logic       err;
  logic       mode_hem = 1'b0;

  int checks = 0;
  int errors = 0;

  // Expected output item: {sop, eop, data}.
  logic [9:0] exp_q[$];

  // Reference model state.
  int         m_state = 0;  // 0 idle, 1 header, 2 data
  int         m_cnt = 0;
  logic [7:0] m_crc = 8'h00;
  logic       m_hem = 1'b0;
  int         exp_err = 0;
  logic [7:0] exp_crc_out = 8'h00;

  int err_seen = 0;
  int bub_cnt = 0;
  bit bub_en = 0;
  bit stall_en = 0;

  bbh_crc8_inserter #(.HDR_LEN(9)) dut (
`ifdef BBH_MODE_XOR_EN
    .mode_hem (mode_hem),
`endif
    .CLK      (CLK),
    .RST      (RST),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_ready(out_ready),
    .crc_out  (crc_out),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-8, poly 0xD5.
  function automatic logic [7:0] ref_crc(input logic [7:0] crc, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[7] ^ b[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'hD5 : 8'h00);
    end
    return crc;
  endfunction

  task automatic model_accept(input logic [7:0] b, input logic s, input logic e);
    logic [7:0] ins;
    if (s) begin
      if (m_state != 0) exp_err++;
      m_crc = ref_crc(8'h00, b);
      m_cnt = 1;
`ifdef BBH_MODE_XOR_EN
      m_hem = mode_hem;
`else
      m_hem = 1'b0;
`endif
      if (e) begin
        exp_q.push_back({1'b1, 1'b1, b});
        exp_err++;
        m_state = 0;
      end else begin
        exp_q.push_back({1'b1, 1'b0, b});
        m_state = 1;
      end
    end else if (m_state == 1) begin
      m_crc = ref_crc(m_crc, b);
      m_cnt++;
      if (m_cnt == 9) begin
        ins = m_crc ^ {7'b0, m_hem};
        exp_q.push_back({1'b0, 1'b0, b});
        exp_q.push_back({1'b0, e, ins});
        exp_crc_out = ins;
        m_state = e ? 0 : 2;
      end else if (e) begin
        exp_q.push_back({1'b0, 1'b1, b});
        exp_err++;
        m_state = 0;
      end else begin
        exp_q.push_back({1'b0, 1'b0, b});
      end
    end else if (m_state == 2) begin
      exp_q.push_back({1'b0, e, b});
      if (e) m_state = 0;
    end
  endtask

  // Presents one byte until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] b, input logic s, input logic e);
    bit done;
    int n;
    done = 0;
    n = 0;
    in_data  = b;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge CLK);
      if (in_ready) begin
        model_accept(b, s, e);
        done = 1;
      end
      @(posedge CLK);
      #1;
      n++;
    end
    if (!done) check("send_timeout", n, 0);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // 00 x8, 01 header with sop on the first byte.
  task automatic send_hdr_d5(input logic last_eop);
    for (int i = 0; i < 8; i++) send(8'h00, i == 0, 1'b0);
    send(8'h01, 1'b0, last_eop);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("err_count", err_seen, exp_err);
    check("crc_out_model", crc_out, exp_crc_out);
  endtask

  // Output ready: constant 1, or the 1,0,0,1 pattern when stalling.
  initial begin
    int idx;
    logic [3:0] pat;
    idx = 0;
    pat = 4'b1001;
    forever begin
      @(posedge CLK);
      #1;
      if (stall_en) begin
        out_ready = pat[3 - idx];
        idx = (idx + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor and scoreboard compare.
  always @(negedge CLK) begin
    if (!RST) begin
      if (err) err_seen++;
      if (bub_en && !in_ready) bub_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", exp_q.size(), 1);
        end else if (out_ready) begin
          check("out_byte", {out_sop, out_eop, out_data}, exp_q.pop_front());
        end else begin
          check("stall_hold", {out_sop, out_eop, out_data}, exp_q[0]);
        end
      end
    end
  end

  initial begin
    int err_before;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_crc_out", crc_out, 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("idle_in_ready", in_ready, 1);

    // Basic frame with data field.
    bub_cnt = 0;
    bub_en = 1;
    send_hdr_d5(1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b1);
    drain();
    bub_en = 0;
    check("bubble_cycles", bub_cnt, 1);
    check("crc_d5", crc_out, 8'hD5);

    // Out-of-frame byte is discarded.
    send(8'h55, 1'b0, 1'b0);

    // All-zero header ending the frame; CRC byte carries eop.
    for (int i = 0; i < 9; i++) send(8'h00, i == 0, i == 8);
    drain();
    check("crc_zero", crc_out, 8'h00);

    // Same frame as the first under output backpressure.
    stall_en = 1;
    send_hdr_d5(1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b1);
    drain();
    stall_en = 0;
    check("stall_crc_d5", crc_out, 8'hD5);

    // Header restarted by a new sop, then a complete frame.
    err_before = err_seen;
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), i == 0, 1'b0);
    send_hdr_d5(1'b0);
    send(8'h3C, 1'b0, 1'b1);
    drain();
    check("restart_err", err_seen - err_before, 1);
    check("restart_crc", crc_out, 8'hD5);

    // Random header frame.
    for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), i == 0, 1'b0);
    send(8'h77, 1'b0, 1'b1);
    drain();

    // Truncated header: eop on header byte 4.
    send_hdr_d5(1'b0);
    send(8'h01, 1'b0, 1'b1);
    drain();
    err_before = err_seen;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), i == 0, i == 3);
    drain();
    check("short_err", err_seen - err_before, 1);
    check("short_crc_keep", crc_out, 8'hD5);

    // Single-byte frame with sop and eop together.
    err_before = err_seen;
    send(8'h42, 1'b1, 1'b1);
    drain();
    check("sopeop_err", err_seen - err_before, 1);

`ifdef BBH_MODE_XOR_EN
    mode_hem = 1'b1;
    send_hdr_d5(1'b0);
    mode_hem = 1'b0;
    send(8'h99, 1'b0, 1'b1);
    drain();
    check("hem_crc_d4", crc_out, 8'hD4);
`endif

    // Reset in the middle of the data field.
    send_hdr_d5(1'b0);
    send(8'hAA, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sop", out_sop, 0);
    check("midrst_out_eop", out_eop, 0);
    check("midrst_crc_out", crc_out, 0);
    check("midrst_err", err, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_q.delete();
    m_state = 0;
    exp_crc_out = 8'h00;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Frame after reset behaves normally.
    send_hdr_d5(1'b0);
    send(8'hEE, 1'b0, 1'b1);
    drain();
    check("post_rst_crc", crc_out, 8'hD5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
